// File: rtl/outbuff_div.sv
// Glitch-free power-of-two clock divider feeding the output/trigger buffer driver.
// Define OUTBUFF_DIV_PCNT_EN to enable the completed-period counter on pcnt_o.
module outbuff_div #(
    parameter int unsigned Nbits     = 3,
    parameter int unsigned Pcnt_bits = 16
) (
    input  logic                 clk_i,
    input  logic                 rstb_i,
    input  logic                 en_i,
    input  logic [Nbits-1:0]     ndiv_i,
    output logic                 clk_out_o,
    output logic                 running_o,
    output logic                 pending_o,
    output logic [Nbits-1:0]     ndiv_act_o,
    output logic [Pcnt_bits-1:0] pcnt_o
);

    localparam int unsigned CntW = 1 << Nbits;

    typedef enum logic {StOff, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [Nbits-1:0]  ndiv_act_q;
    logic              clk_out_q;
    logic [CntW-1:0]   half_m1;
    logic              at_toggle;
    logic              at_boundary;

    assign half_m1     = (CntW'(1) << ndiv_act_q) - CntW'(1);
    assign at_toggle   = (state_q == StRun) && (cnt_q == half_m1);
    // Config changes only land on the falling toggle, so no runt phase is ever emitted.
    assign at_boundary = at_toggle && clk_out_q;

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            ndiv_act_q <= '0;
            clk_out_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    cnt_q     <= '0;
                    clk_out_q <= 1'b0;
                    if (en_i) begin
                        state_q    <= StRun;
                        ndiv_act_q <= ndiv_i;
                    end
                end
                StRun: begin
                    if (at_toggle) begin
                        cnt_q     <= '0;
                        clk_out_q <= ~clk_out_q;
                        if (clk_out_q) begin
                            ndiv_act_q <= ndiv_i;
                            if (!en_i) begin
                                state_q <= StOff;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

`ifdef OUTBUFF_DIV_PCNT_EN
    logic [Pcnt_bits-1:0] pcnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstb_i) begin
            pcnt_q <= '0;
        end else if (at_boundary) begin
            pcnt_q <= pcnt_q + Pcnt_bits'(1);
        end
    end

    assign pcnt_o = pcnt_q;
`else
    assign pcnt_o = '0;
`endif

    assign clk_out_o  = clk_out_q;
    assign running_o  = (state_q == StRun);
    assign ndiv_act_o = ndiv_act_q;
    assign pending_o  = (en_i != running_o) | (ndiv_i != ndiv_act_q);

endmodule

// File: tb/tb_outbuff_div.sv
// Scoreboard bench for outbuff_div: expected clk_out phases are queued, a monitor checks them.
module tb_outbuff_div;

    localparam int unsigned Nbits     = 3;
    localparam int unsigned Pcnt_bits = 16;
    localparam int          B         = 10;

    logic                 clk;
    logic                 rstb;
    logic                 en;
    logic [Nbits-1:0]     ndiv;
    logic                 clk_out;
    logic                 running;
    logic                 pending;
    logic [Nbits-1:0]     ndiv_act;
    logic [Pcnt_bits-1:0] pcnt;

    outbuff_div #(
        .Nbits     (Nbits),
        .Pcnt_bits (Pcnt_bits)
    ) dut (
        .clk_i      (clk),
        .rstb_i     (rstb),
        .en_i       (en),
        .ndiv_i     (ndiv),
        .clk_out_o  (clk_out),
        .running_o  (running),
        .pending_o  (pending),
        .ndiv_act_o (ndiv_act),
        .pcnt_o     (pcnt)
    );

    typedef struct {
        bit lvl;
        int len;
        int pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit lvl, input int len, input int pc);
        exp_t e;
        e.lvl = lvl;
        e.len = len;
        e.pc  = pc;
        exp_q.push_back(e);
    endtask

    function automatic int pe(input int k);
`ifdef OUTBUFF_DIV_PCNT_EN
        return k;
`else
        return 0;
`endif
    endfunction

    // Monitor: every clk_out transition is matched against the next queued phase.
    initial begin
        logic prev;
        int   since;
        exp_t e;
        prev  = 1'b0;
        since = 0;
        forever begin
            @(negedge clk);
            since = since + 1;
            if (clk_out !== prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", int'(clk_out), int'(prev));
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_level", int'(clk_out), int'(e.lvl));
                    if (e.len != 0) chk("phase_len", since, e.len);
                    if (e.pc >= 0) chk("pcnt_at_fall", int'(pcnt), e.pc);
                end
                prev  = clk_out;
                since = 0;
            end
        end
    end

    initial begin
        rstb = 1'b0;
        en   = 1'b0;
        ndiv = '0;

        // Reset state and pending during reset
        at(3);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_ndiv_act", int'(ndiv_act), 0);
        chk("rst_pcnt", int'(pcnt), 0);
        ndiv = 3'd5;
        #1;
        chk("rst_pending_ndiv", int'(pending), 1);
        at(5);
        ndiv = '0;
        en   = 1'b1;
        #1;
        chk("rst_pending_en", int'(pending), 1);
        at(9);
        chk("rst_hold_running", int'(running), 0);

        // Scenarios 1/2: ndiv=0, then ndiv=2 steady
        push(1, 0, -1);
        push(0, 1, pe(1));
        push(1, 1, -1);
        push(0, 1, pe(2));
        for (int k = 3; k <= 10; k++) begin
            push(1, 4, -1);
            push(0, 4, pe(k));
        end
        // Scenario 3: 2 -> 0 mid-high, then 3 queued for scenario 4
        push(1, 4, -1);
        push(0, 4, pe(11));
        push(1, 1, -1);
        push(0, 1, pe(12));
        push(1, 8, -1);
        push(0, 8, pe(13));
        push(1, 0, -1);
        push(0, 8, pe(14));
        push(1, 8, -1);
        push(0, 8, pe(15));
        // Scenario 5: ndiv=1, reset mid-high, restart, then disable
        push(1, 2, -1);
        push(0, 2, pe(16));
        push(1, 2, -1);
        push(0, 1, pe(0));
        push(1, 0, -1);
        push(0, 2, pe(1));
        push(1, 2, -1);
        push(0, 2, pe(2));
        push(1, 2, -1);
        push(0, 2, pe(3));

        at(B);
        rstb = 1'b1;
        at(B + 1);
        chk("en_running", int'(running), 1);
        chk("en_pending", int'(pending), 0);
        chk("en_clk_low", int'(clk_out), 0);
        at(B + 2);
        chk("first_rise_n0", int'(clk_out), 1);

        at(B + 4);
        ndiv = 3'd2;
        #1;
        chk("pend_ndiv2", int'(pending), 1);
        at(B + 5);
        chk("ndiv_act_2", int'(ndiv_act), 2);
        chk("pend_clear_2", int'(pending), 0);
        at(B + 69);
        chk("pcnt_10", int'(pcnt), pe(10));

        at(B + 74);
        ndiv = 3'd0;
        #1;
        chk("pend_ndiv0", int'(pending), 1);
        chk("ndiv_act_hold", int'(ndiv_act), 2);
        at(B + 77);
        chk("ndiv_act_0", int'(ndiv_act), 0);
        chk("pend_clear_0", int'(pending), 0);
        at(B + 78);
        ndiv = 3'd3;

        // Scenario 4: disable mid-high at ndiv=3
        at(B + 89);
        en = 1'b0;
        #1;
        chk("dis_pending", int'(pending), 1);
        chk("dis_running_hold", int'(running), 1);
        at(B + 94);
        chk("dis_high_hold", int'(clk_out), 1);
        chk("dis_running_94", int'(running), 1);
        at(B + 95);
        chk("dis_running_off", int'(running), 0);
        chk("dis_clk_low", int'(clk_out), 0);
        chk("dis_pending_clr", int'(pending), 0);
        at(B + 115);
        en = 1'b1;
        at(B + 116);
        chk("reen_running", int'(running), 1);
        at(B + 123);
        chk("reen_pre_rise", int'(clk_out), 0);
        at(B + 124);
        chk("reen_rise", int'(clk_out), 1);

        at(B + 135);
        ndiv = 3'd1;
        at(B + 148);
        chk("ndiv_act_1", int'(ndiv_act), 1);

        at(B + 154);
        rstb = 1'b0;
        at(B + 155);
        chk("mid_rst_clk", int'(clk_out), 0);
        chk("mid_rst_running", int'(running), 0);
        chk("mid_rst_pcnt", int'(pcnt), 0);
        chk("mid_rst_ndiv_act", int'(ndiv_act), 0);
        chk("mid_rst_pending", int'(pending), 1);
        rstb = 1'b1;
        at(B + 157);
        chk("rst_restart_low", int'(clk_out), 0);
        at(B + 158);
        chk("rst_restart_rise", int'(clk_out), 1);
        chk("rst_restart_run", int'(running), 1);

        at(B + 165);
        en = 1'b0;
        at(B + 168);
        chk("final_off", int'(running), 0);
        at(B + 180);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
